// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI mode-0 slave emulating a serial NOR flash (READ, READ STATUS, JEDEC ID)
// Define FAST_READ_EN to accept FAST READ (0x0B) with one dummy byte before data.
module spi_flash_responder #(
   parameter int          ADDR_W      = 24,
   parameter logic [23:0] JEDEC_ID    = 24'hEF4017,
   parameter int          SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_sck,
   input  logic              spi_cs_n,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_data,
   output logic              busy,
   output logic              cmd_err
);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_CMD     = 4'd1;
   localparam logic [3:0] S_ADDR    = 4'd2;
   localparam logic [3:0] S_DATA    = 4'd3;
   localparam logic [3:0] S_STAT    = 4'd4;
   localparam logic [3:0] S_ID      = 4'd5;
   localparam logic [3:0] S_IGNORE  = 4'd6;
   localparam logic [3:0] S_WAIT_CS = 4'd7;
`ifdef FAST_READ_EN
   localparam logic [3:0] S_DUMMY   = 4'd8;
`endif

   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_sck_prev;
   logic                   r_cs_prev;
   logic [3:0]             r_state;
   logic [2:0]             r_bit_cnt;
   logic [6:0]             r_rx_sh;
   logic [7:0]             r_tx_sh;
   logic [1:0]             r_idx;
   logic [15:0]            r_addr_hi;
   logic                   r_load;
`ifdef FAST_READ_EN
   logic                   r_fast;
`endif

   logic                   w_sck_s;
   logic                   w_cs_s;
   logic                   w_mosi_s;
   logic                   w_rise;
   logic                   w_fall;
   logic                   w_cs_fall;
   logic                   w_byte_done;
   logic                   w_shifting;
   logic [7:0]             w_rx_byte;
   logic [23:0]            w_addr_full;

   // CS_N synchroniser resets as "selected" so a frame already running at reset release lands in WAIT_CS.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sck_sync  <= '0;
         r_cs_sync   <= '0;
         r_mosi_sync <= '0;
         r_sck_prev  <= 1'b0;
         r_cs_prev   <= 1'b0;
      end else begin
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         r_sck_prev  <= w_sck_s;
         r_cs_prev   <= w_cs_s;
      end
   end

   assign w_sck_s     = r_sck_sync[SYNC_STAGES-1];
   assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
   assign w_rise      = w_sck_s & ~r_sck_prev;
   assign w_fall      = ~w_sck_s & r_sck_prev;
   assign w_cs_fall   = ~w_cs_s & r_cs_prev;
   assign w_rx_byte   = {r_rx_sh, w_mosi_s};
   assign w_byte_done = w_rise && (r_bit_cnt == 3'd7);
   assign w_addr_full = {r_addr_hi, w_rx_byte};
   assign w_shifting  = (r_state == S_DATA) || (r_state == S_STAT) || (r_state == S_ID);
   assign busy        = (r_state != S_IDLE) && (r_state != S_WAIT_CS);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_bit_cnt   <= 3'd0;
         r_rx_sh     <= 7'd0;
         r_tx_sh     <= 8'h00;
         r_idx       <= 2'd0;
         r_addr_hi   <= 16'h0000;
         r_load      <= 1'b0;
`ifdef FAST_READ_EN
         r_fast      <= 1'b0;
`endif
         spi_miso    <= 1'b0;
         spi_miso_oe <= 1'b0;
         mem_addr    <= '0;
         mem_rd      <= 1'b0;
         cmd_err     <= 1'b0;
      end else begin
         mem_rd  <= 1'b0;
         cmd_err <= 1'b0;
         r_load  <= mem_rd;
         // Read data lands one clk after the strobe; capture it and post-increment.
         if (r_load) begin
            r_tx_sh  <= mem_data;
            mem_addr <= mem_addr + ADDR_W'(1);
         end
         if (w_cs_s) begin
            r_state     <= S_IDLE;
            spi_miso_oe <= 1'b0;
            r_bit_cnt   <= 3'd0;
         end else begin
            if (w_cs_fall) begin
               r_bit_cnt <= 3'd0;
            end else if (w_rise) begin
               r_bit_cnt <= r_bit_cnt + 3'd1;
               r_rx_sh   <= w_rx_byte[6:0];
            end
            if (w_fall && w_shifting) begin
               spi_miso    <= r_tx_sh[7];
               r_tx_sh     <= {r_tx_sh[6:0], 1'b0};
               spi_miso_oe <= 1'b1;
            end
            case (r_state)
               S_IDLE: r_state <= w_cs_fall ? S_CMD : S_WAIT_CS;
               S_CMD: begin
                  if (w_byte_done) begin
                     r_idx <= 2'd0;
                     case (w_rx_byte)
                        8'h03: begin
                           r_state <= S_ADDR;
`ifdef FAST_READ_EN
                           r_fast  <= 1'b0;
`endif
                        end
`ifdef FAST_READ_EN
                        8'h0B: begin
                           r_state <= S_ADDR;
                           r_fast  <= 1'b1;
                        end
`endif
                        8'h05: begin
                           r_state <= S_STAT;
                           r_tx_sh <= 8'h00;
                        end
                        8'h9F: begin
                           r_state <= S_ID;
                           r_tx_sh <= JEDEC_ID[23:16];
                           r_idx   <= 2'd1;
                        end
                        default: begin
                           r_state <= S_IGNORE;
                           cmd_err <= 1'b1;
                        end
                     endcase
                  end
               end
               S_ADDR: begin
                  if (w_byte_done) begin
                     r_addr_hi <= {r_addr_hi[7:0], w_rx_byte};
                     if (r_idx == 2'd2) begin
                        mem_addr <= ADDR_W'(w_addr_full);
`ifdef FAST_READ_EN
                        if (r_fast) begin
                           r_state <= S_DUMMY;
                        end else begin
                           mem_rd  <= 1'b1;
                           r_state <= S_DATA;
                        end
`else
                        mem_rd  <= 1'b1;
                        r_state <= S_DATA;
`endif
                     end else begin
                        r_idx <= r_idx + 2'd1;
                     end
                  end
               end
`ifdef FAST_READ_EN
               S_DUMMY: begin
                  if (w_byte_done) begin
                     mem_rd  <= 1'b1;
                     r_state <= S_DATA;
                  end
               end
`endif
               S_DATA: begin
                  if (w_byte_done) begin
                     mem_rd <= 1'b1;
                  end
               end
               S_STAT: begin
                  if (w_byte_done) begin
                     r_tx_sh <= 8'h00;
                  end
               end
               S_ID: begin
                  if (w_byte_done) begin
                     case (r_idx)
                        2'd1:    r_tx_sh <= JEDEC_ID[15:8];
                        2'd2:    r_tx_sh <= JEDEC_ID[7:0];
                        default: r_tx_sh <= 8'h00;
                     endcase
                     if (r_idx != 2'd3) begin
                        r_idx <= r_idx + 2'd1;
                     end
                  end
               end
               S_IGNORE:  r_state <= S_IGNORE;
               S_WAIT_CS: r_state <= S_WAIT_CS;
               default:   r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - scoreboard bench for spi_flash_responder
// Bus monitors pop expected MISO bytes and mem_rd addresses queued by the stimulus tasks.
module tb_spi_flash_responder;
   localparam int ADDR_W      = 24;
   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 6;

   logic              clk      = 1'b0;
   logic              rst      = 1'b1;
   logic              spi_sck  = 1'b0;
   logic              spi_cs_n = 1'b1;
   logic              spi_mosi = 1'b0;
   logic [7:0]        mem_data = 8'h00;
   logic              spi_miso;
   logic              spi_miso_oe;
   logic              mem_rd;
   logic              busy;
   logic              cmd_err;
   logic [ADDR_W-1:0] mem_addr;

   spi_flash_responder #(
      .ADDR_W(ADDR_W),
      .JEDEC_ID(24'hEF4017),
      .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk(clk),
      .rst(rst),
      .spi_sck(spi_sck),
      .spi_cs_n(spi_cs_n),
      .spi_mosi(spi_mosi),
      .spi_miso(spi_miso),
      .spi_miso_oe(spi_miso_oe),
      .mem_addr(mem_addr),
      .mem_rd(mem_rd),
      .mem_data(mem_data),
      .busy(busy),
      .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  mem [bit [23:0]];
   logic [7:0]  exp_miso [$];
   logic [23:0] exp_addr [$];
   logic [7:0]  tx_q [$];
   int          err_pulses = 0;
   bit          oe_any = 1'b0;
   bit          busy_watch = 1'b0;
   bit          busy_drop = 1'b0;
   logic [7:0]  mon_byte = 8'h00;
   int          mon_bits = 0;
   bit          mon_oe = 1'b0;

   function automatic logic [7:0] mem_get(input logic [23:0] a);
      if (!mem.exists(a)) mem[a] = 8'($urandom);
      return mem[a];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      if (mem_rd === 1'b1) mem_data <= mem_get(mem_addr);
   end

   // Master-side view: sample MISO on each SCK rise, judge every byte that was driven.
   always @(posedge spi_sck or posedge spi_cs_n) begin
      if (spi_cs_n) begin
         mon_bits = 0;
         mon_oe   = 1'b0;
      end else begin
         mon_byte = {mon_byte[6:0], spi_miso};
         if (spi_miso_oe === 1'b1) mon_oe = 1'b1;
         mon_bits++;
         if (mon_bits == 8) begin
            if (mon_oe) begin
               check("miso_expected", 32'(exp_miso.size() != 0), 1);
               if (exp_miso.size() != 0) check("miso_byte", 32'(mon_byte), 32'(exp_miso.pop_front()));
            end
            mon_bits = 0;
            mon_oe   = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (spi_miso_oe === 1'b1) oe_any = 1'b1;
      if (cmd_err === 1'b1) err_pulses++;
      if (busy_watch && busy !== 1'b1) busy_drop = 1'b1;
      if (mem_rd === 1'b1) begin
         check("mem_rd_expected", 32'(exp_addr.size() != 0), 1);
         if (exp_addr.size() != 0) check("mem_rd_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic spi_byte(input logic [7:0] b, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_mosi = b[i];
         repeat (HALF) @(negedge clk);
         spi_sck = 1'b1;
         repeat (HALF) @(negedge clk);
         spi_sck = 1'b0;
      end
   endtask

   task automatic cs_low();
      repeat (HALF) @(negedge clk);
      err_pulses = 0;
      oe_any     = 1'b0;
      busy_drop  = 1'b0;
      spi_cs_n   = 1'b0;
      repeat (HALF) @(negedge clk);
      busy_watch = 1'b1;
   endtask

   task automatic end_frame();
      repeat (HALF) @(negedge clk);
      busy_watch = 1'b0;
      spi_cs_n   = 1'b1;
      repeat (SYNC_STAGES + 1) @(posedge clk);
      @(negedge clk);
      check("busy_release", 32'(busy), 0);
      check("oe_release", 32'(spi_miso_oe), 0);
      repeat (HALF) @(negedge clk);
   endtask

   task automatic send_frame(input int tail_bits);
      cs_low();
      foreach (tx_q[i]) spi_byte(tx_q[i], 8);
      if (tail_bits > 0) spi_byte(8'hFF, tail_bits);
      end_frame();
   endtask

   task automatic post_frame(input int exp_err);
      check("cmd_err_pulses", 32'(err_pulses), 32'(exp_err));
      check("miso_leftover", 32'(exp_miso.size()), 0);
      check("mem_rd_leftover", 32'(exp_addr.size()), 0);
      exp_miso.delete();
      exp_addr.delete();
   endtask

   task automatic do_read(input logic [23:0] addr, input int n, input bit fast);
      logic [23:0] a;
      tx_q.delete();
      tx_q.push_back(fast ? 8'h0B : 8'h03);
      tx_q.push_back(addr[23:16]);
      tx_q.push_back(addr[15:8]);
      tx_q.push_back(addr[7:0]);
      if (fast) tx_q.push_back(8'($urandom));
      for (int i = 0; i < n; i++) begin
         a = addr + 24'(i);
         exp_miso.push_back(mem_get(a));
         exp_addr.push_back(a);
         tx_q.push_back(8'($urandom));
      end
      exp_addr.push_back(addr + 24'(n));
      send_frame(0);
      a = addr + 24'(n + 1);
      check("read_busy_held", 32'(busy_drop), 0);
      check("read_end_addr", 32'(mem_addr), 32'(a));
      post_frame(0);
   endtask

   task automatic do_id(input int n);
      logic [23:0] id;
      id = 24'hEF4017;
      tx_q.delete();
      tx_q.push_back(8'h9F);
      for (int i = 0; i < n; i++) begin
         exp_miso.push_back((i < 3) ? id[23 - 8*i -: 8] : 8'h00);
         tx_q.push_back(8'($urandom));
      end
      send_frame(0);
      check("id_busy_held", 32'(busy_drop), 0);
      post_frame(0);
   endtask

   task automatic do_stat(input int n);
      tx_q.delete();
      tx_q.push_back(8'h05);
      for (int i = 0; i < n; i++) begin
         exp_miso.push_back(8'h00);
         tx_q.push_back(8'($urandom));
      end
      send_frame(0);
      check("stat_busy_held", 32'(busy_drop), 0);
      post_frame(0);
   endtask

   task automatic do_bad(input logic [7:0] op, input int n);
      tx_q.delete();
      tx_q.push_back(op);
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
      send_frame(0);
      check("bad_oe_silent", 32'(oe_any), 0);
      post_frame(1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_miso"}, 32'(spi_miso), 0);
      check({tag, "_oe"}, 32'(spi_miso_oe), 0);
      check({tag, "_addr"}, 32'(mem_addr), 0);
      check({tag, "_rd"}, 32'(mem_rd), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_cmd_err"}, 32'(cmd_err), 0);
   endtask

   task automatic reset_mid_data();
      tx_q.delete();
      tx_q.push_back(8'h03);
      tx_q.push_back(8'h00);
      tx_q.push_back(8'h02);
      tx_q.push_back(8'h00);
      exp_addr.push_back(24'h000200);
      exp_addr.push_back(24'h000201);
      exp_miso.push_back(mem_get(24'h000200));
      cs_low();
      foreach (tx_q[i]) spi_byte(tx_q[i], 8);
      spi_byte(8'hFF, 8);
      repeat (HALF) @(negedge clk);
      busy_watch = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("mid_rst");
      rst    = 1'b1;
      oe_any = 1'b0;
      spi_byte(8'h03, 8);
      spi_byte(8'h00, 8);
      check("wait_cs_oe", 32'(oe_any), 0);
      check("wait_cs_busy", 32'(busy), 0);
      end_frame();
      post_frame(0);
   endtask

   int          op;
   int          n;
   logic [23:0] ra;
   logic [23:0] held;
   logic [7:0]  bad;

   initial begin
      mem[24'h000100] = 8'hA5;
      mem[24'h000101] = 8'h3C;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;
      repeat (10) @(negedge clk);

      do_read(24'h000100, 2, 1'b0);
      do_id(4);
      do_bad(8'hAB, 2);
      do_stat(1);
      do_read(24'hFFFFFF, 2, 1'b0);

      held = mem_addr;
      tx_q.delete();
      tx_q.push_back(8'h03);
      tx_q.push_back(8'h00);
      send_frame(4);
      check("abort_addr_held", 32'(mem_addr), 32'(held));
      post_frame(0);
      do_read(24'h000010, 1, 1'b0);

      reset_mid_data();
      do_read(24'h000010, 1, 1'b0);
`ifdef FAST_READ_EN
      do_read(24'h000010, 1, 1'b1);
`else
      do_bad(8'h0B, 1);
`endif

      for (int it = 0; it < 20; it++) begin
         op = $urandom_range(0, 3);
         n  = $urandom_range(1, 4);
         case (op)
            0: begin
               if ($urandom_range(0, 1) == 1) ra = 24'hFFFFFF - 24'($urandom_range(0, 2));
               else ra = 24'($urandom);
               do_read(ra, n, 1'b0);
            end
            1: do_id(n);
            2: do_stat(n);
            default: begin
               do begin
                  bad = 8'($urandom);
`ifdef FAST_READ_EN
               end while (bad == 8'h03 || bad == 8'h05 || bad == 8'h9F || bad == 8'h0B);
`else
               end while (bad == 8'h03 || bad == 8'h05 || bad == 8'h9F);
`endif
               do_bad(bad, n);
            end
         endcase
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- SPI mode-0 slave that emulates a serial NOR flash on the far end of the flash-reader bus, for bench self-check and for FPGA-to-FPGA audio streaming.
- Decodes READ (0x03), READ STATUS (0x05) and JEDEC ID (0x9F).
- Serves read data from a byte-wide synchronous memory port (ROM/BRAM holding 8-bit PCM).
- All logic runs on the local clk; SCK/CS/MOSI are oversampled, and SCK is never used as a clock.

Parameters:
- ADDR_W, 24: flash address width; the address counter wraps modulo 2^ADDR_W.
- JEDEC_ID, 24'hEF4017: ID bytes returned MSB-first for opcode 0x9F.
- SYNC_STAGES, 2: synchroniser depth on SCK, CS_N and MOSI (minimum 2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- spi_sck  in  1  SPI clock from master, idle low
- spi_cs_n  in  1  chip select, active-low
- spi_mosi  in  1  master-out data
- spi_miso  out  1  slave-out data
- spi_miso_oe  out  1  MISO output enable (pad tri-state control)
- mem_addr  out  ADDR_W  memory read address
- mem_rd  out  1  one-cycle read strobe; mem_data is valid the following clk
- mem_data  in  8  memory read data
- busy  out  1  high while CS_N is low and a command is being decoded or served
- cmd_err  out  1  one-cycle pulse when an opcode is unsupported

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, mem_addr=0, mem_rd=0, busy=0, cmd_err=0, state=IDLE.
- Timing constraint: each SCK half-period must be ≥4 clk cycles; edges arriving faster are undefined.
- Input sync: SYNC_STAGES FFs per input, then edge detect on the synced signals.
  - rise = synced SCK 0→1; fall = 1→0.
  - cs_act = synced CS_N low.
- Bit counter: 3 bits, cleared when CS_N falls. Each rise samples MOSI into rx_sh (MSB-first) and increments the counter. Byte complete = counter wraps 7→0.
- States and transitions:
  - IDLE: on cs_act go to CMD and set busy=1.
  - CMD: on byte complete, decode:
    - 0x03 → ADDR, byte index 0.
    - 0x05 → STAT.
    - 0x9F → ID, index 0.
    - Any other → IGNORE, with cmd_err pulsed for 1 clk.
  - ADDR: three bytes form the address MSB-first.
    - On the third byte complete, in the same clk: mem_addr<=address, mem_rd=1.
    - Next clk: tx_sh<=mem_data, mem_addr<=mem_addr+1 (wraps to 0).
    - Go to DATA.
  - DATA:
    - Every fall: spi_miso<=tx_sh[7], tx_sh shifts left, spi_miso_oe=1.
    - On every byte complete: mem_rd for mem_addr, then reload tx_sh and post-increment as in ADDR. The next MSB is therefore ready before the following fall.
    - Streams indefinitely until CS_N rises.
  - STAT: tx_sh=8'h00 reloaded every byte (never busy, WEL=0), shifted as in DATA.
  - ID: JEDEC_ID[23:16], then [15:8], then [7:0], then 8'h00 repeatedly.
  - IGNORE: spi_miso_oe=0; MOSI discarded.
  - WAIT_CS: entered from reset release if CS_N is already low. The slave stays silent (oe=0) until CS_N rises, so no partial frame is decoded.
- CS_N rise in any state:
  - Within 1 clk after sync: state=IDLE, spi_miso_oe=0, busy=0.
  - spi_miso holds its last value.
  - Bit counter cleared; mem_addr holds.
- MISO before the first data fall: spi_miso_oe=0 during CMD and ADDR. Data appears on the fall that follows the last command/address bit.
- mem_rd is never asserted outside ADDR completion or a DATA byte completion. At most one mem_rd per 8 SCK cycles.
- Simultaneous CS_N rise and byte complete: CS_N wins; no mem_rd is issued.
- Address 2^ADDR_W−1 is followed by 0.

Optional Feature:
- Macro FAST_READ_EN.
- Defined:
  - Opcode 0x0B (FAST READ) accepted.
  - After the 3 address bytes, the slave enters DUMMY for exactly 8 SCK rises with oe=0. The first mem_rd is issued at the end of DUMMY, then behaviour is as DATA.
- Undefined: 0x0B is treated as unsupported (cmd_err pulse, IGNORE).

Test Plan:
- Memory preloaded with mem[0x000100]=0xA5, mem[0x000101]=0x3C. Master sends 03 00 01 00 FF FF → MISO bytes during the last two bytes are 0xA5, 0x3C; exactly 3 mem_rd pulses; mem_addr ends at 0x000103.
- Send 9F plus 4 dummy bytes → MISO reads EF 40 17 00; busy=1 throughout; busy=0 within SYNC_STAGES+1 clk of CS_N rise.
- Send 0xAB → cmd_err pulses once, 1 clk wide; spi_miso_oe stays 0 for the whole frame; the next frame, 05 FF, returns 0x00.
- Read from address 0xFFFFFF for 2 data bytes → mem_addr sequence FFFFFF, 000000; data matches mem[0xFFFFFF], mem[0x000000].
- CS_N raised after 4 bits of the second address byte; then a new 03 00 00 10 FF frame is sent → returns mem[0x10]; no stray mem_rd from the aborted frame.
- rst pulsed mid-DATA with CS_N held low → all outputs return to reset values; oe stays 0 until CS_N toggles high then low; the following READ frame works. With FAST_READ_EN defined, 0B 00 00 10 xx FF → returns mem[0x10].
